mbist_march_ctrl: RTL and testbench

- Memory BIST controller that runs the March C- algorithm on one single-port fault_mem-style memory.
- Port style matches that memory: write_read, address, wdata, rdata.
- Generates the address/data/op stream, honours the memory's one-cycle write-data skew and two-cycle read latency, compares read data against expected values, and reports pass/fail with first-failure capture.
- Sits between the test top/TAP logic and the memory under test.

---
 rtl/mbist_mem_if.sv | 25 ++
 rtl/mbist_march_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_mem_if.sv
// Memory-side bus of the March C- BIST controller.
// Same signal set as the single-port fault_mem under test.
interface mbist_mem_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  mem_write_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_write_read,
        output mem_address,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_write_read,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller for a single-port memory with
// one-cycle write-data skew and two-cycle read latency.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    mbist_mem_if.master           mem
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] exp;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
    } tag_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY - 1);
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    state_t                state, next_state;
    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ph;
    logic [1:0]            drain_cnt;
    tag_t                  t1, t2, t3;

    logic                  two_op, down, last_ph, addr_end, run_last;
    logic                  op_we, mismatch, drain_end;
    logic [DATA_WIDTH-1:0] rd_exp, wr_val;

    // Decode the current op from element, address and phase.
    always_comb begin
        two_op   = (elem != 3'd0) && (elem != 3'd5);
        down     = (elem == 3'd3) || (elem == 3'd4);
        op_we    = (elem == 3'd0) || (two_op && ph);
        last_ph  = !two_op || ph;
        addr_end = down ? (addr == '0) : (addr == LAST);
        run_last = (elem == 3'd5) && addr_end;
        rd_exp   = ((elem == 3'd2) || (elem == 3'd4)) ? ONES : '0;
        wr_val   = ((elem == 3'd1) || (elem == 3'd3)) ? ONES : '0;
        drain_end = (state == DRAIN) && (drain_cnt == 2'd3);
        mismatch = t3.valid && (mem.mem_rdata !== t3.exp);
    end

    // Write data leads the write strobe, so it follows the live op.
    assign mem.mem_wdata = (state == RUN && op_we) ? wr_val : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (run_last) next_state = DRAIN;
            DRAIN:   if (drain_cnt == 2'd3) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Op generator: one op per cycle, parked at E0/addr 0 outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem <= '0;
            addr <= '0;
            ph   <= 1'b0;
        end else if (state != RUN) begin
            elem <= '0;
            addr <= '0;
            ph   <= 1'b0;
        end else if (!last_ph) begin
            ph <= 1'b1;
        end else begin
            ph <= 1'b0;
            if (!addr_end) begin
                addr <= down ? addr - ADDR_WIDTH'(1)
                             : addr + ADDR_WIDTH'(1);
            end else begin
                elem <= elem + 3'd1;
                addr <= (elem == 3'd2 || elem == 3'd3) ? LAST : '0;
            end
        end
    end

    // Strobe/address lag wdata by a cycle; read tags follow the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_write_read <= 1'b0;
            mem.mem_address    <= '0;
            t1 <= '0;
            t2 <= '0;
            t3 <= '0;
        end else begin
            if (state == RUN) begin
                mem.mem_write_read <= op_we;
                mem.mem_address    <= addr;
                t1 <= '{valid: !op_we, exp: rd_exp,
                        addr: addr, elem: elem};
            end else begin
                mem.mem_write_read <= 1'b0;
                mem.mem_address    <= '0;
                t1 <= '0;
            end
            t2 <= t1;
            t3 <= t2;
        end
    end

    // Drain counter covers the three tag stages plus the compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              drain_cnt <= '0;
        else if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
        else                     drain_cnt <= '0;
    end

    // Run status, mismatch counting and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                busy       <= 1'b1;
                pass       <= 1'b0;
                fail_count <= '0;
                fail_addr  <= '0;
                fail_elem  <= '0;
                fail_data  <= '0;
            end else if (mismatch) begin
                if (fail_count != '1)
                    fail_count <= fail_count + CNT_WIDTH'(1);
                if (fail_count == '0) begin
                    fail_addr <= t3.addr;
                    fail_elem <= t3.elem;
                    fail_data <= mem.mem_rdata;
                end
            end
            if (drain_end) begin
                done <= 1'b1;
                busy <= 1'b0;
                pass <= (fail_count == '0);
            end
        end
    end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl with a behavioural
// single-port memory that can inject stuck-at and coupling faults.
module tb_mbist_march_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [7:0] fail_count;
    logic [3:0] fail_addr;
    logic [2:0] fail_elem;
    logic [7:0] fail_data;

    int errs = 0;
    int checks = 0;
    int fault = 0;
    int wr_cnt = 0;

    typedef struct {
        int cyc;
        bit pass;
        int cnt;
        int addr;
        int elem;
        int data;
    } exp_t;

    exp_t sb[$];

    mbist_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) mif ();

    mbist_march_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4),
        .CAPACITY(16), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .fail_addr(fail_addr),
        .fail_elem(fail_elem), .fail_data(fail_data),
        .mem(mif)
    );

    always #5 clk = ~clk;

    // Behavioural memory: registered wdata, 2-cycle read latency.
    logic [7:0] mem_arr [16];
    logic [7:0] wq, r1, r2;
    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = 8'h00;
        wq = 8'h00;
        r1 = 8'h00;
        r2 = 8'h00;
    end
    assign mif.mem_rdata = r2;

    always @(posedge clk) begin
        wq <= mif.mem_wdata;
        if (mif.mem_write_read) begin
            mem_arr[mif.mem_address] <= wq;
            if (fault == 2 && mif.mem_address == 4'd4 &&
                mem_arr[4][5] && !wq[5])
                mem_arr[5] <= ~mem_arr[5];
        end else begin
            if (fault == 1 && mif.mem_address == 4'd3)
                r1 <= mem_arr[3] | 8'h01;
            else
                r1 <= mem_arr[mif.mem_address];
        end
        r2 <= r1;
    end

    always @(posedge clk) if (mif.mem_write_read === 1'b1) wr_cnt++;

    task automatic wait_done(input int pulse_at, input int abort_at,
                             inout int cyc);
        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == pulse_at - 1) start = 1'b1;
            if (cyc == pulse_at) start = 1'b0;
            if (cyc == abort_at) return;
            if (done === 1'b1) return;
        end
    endtask

    task automatic do_run(input int pulse_at, input int abort_at,
                          input bit hold, output int cyc);
        start = 1'b1;
        @(posedge clk);
        wr_cnt = 0;
        #1;
        if (!hold) start = 1'b0;
        cyc = 0;
        wait_done(pulse_at, abort_at, cyc);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            errs++;
            $display("FAIL reset_flags: got %b want 000",
                     {busy, done, pass});
        end
        checks++;
        if ({fail_count, fail_addr, fail_elem, fail_data} !== '0) begin
            errs++;
            $display("FAIL reset_fail: got %h want 0",
                     {fail_count, fail_addr, fail_elem, fail_data});
        end
        checks++;
        if ({mif.mem_write_read, mif.mem_address, mif.mem_wdata}
            !== 13'd0) begin
            errs++;
            $display("FAIL reset_mem: got %h want 0",
                     {mif.mem_write_read, mif.mem_address,
                      mif.mem_wdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fault_free();
        int c;
        exp_t e;
        fault = 0;
        sb.push_back('{164, 1'b1, 0, 0, 0, 0});
        do_run(-10, -1, 1'b0, c);
        e = sb.pop_front();
        checks++;
        if (c != e.cyc) begin
            errs++;
            $display("FAIL ff_done_cyc: got %0d want %0d", c, e.cyc);
        end
        checks++;
        if (pass !== e.pass) begin
            errs++;
            $display("FAIL ff_pass: got %b want %b", pass, e.pass);
        end
        checks++;
        if (fail_count !== 8'(e.cnt)) begin
            errs++;
            $display("FAIL ff_count: got %0d want %0d",
                     fail_count, e.cnt);
        end
        checks++;
        if (wr_cnt != 80) begin
            errs++;
            $display("FAIL ff_writes: got %0d want 80", wr_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL ff_busy_at_done: got %b want 0", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || pass !== 1'b1) begin
            errs++;
            $display("FAIL ff_done_pulse: got done=%b pass=%b want 0 1",
                     done, pass);
        end
    endtask

    task automatic test_stuck();
        int c;
        exp_t e;
        fault = 1;
        sb.push_back('{164, 1'b0, 3, 3, 1, 1});
        do_run(-10, -1, 1'b0, c);
        e = sb.pop_front();
        checks++;
        if (c != e.cyc || pass !== e.pass) begin
            errs++;
            $display("FAIL sa_done: got cyc=%0d pass=%b want %0d %b",
                     c, pass, e.cyc, e.pass);
        end
        checks++;
        if (fail_count !== 8'(e.cnt)) begin
            errs++;
            $display("FAIL sa_count: got %0d want %0d",
                     fail_count, e.cnt);
        end
        checks++;
        if (fail_addr !== 4'(e.addr) || fail_elem !== 3'(e.elem)) begin
            errs++;
            $display("FAIL sa_where: got a=%0d e=%0d want a=%0d e=%0d",
                     fail_addr, fail_elem, e.addr, e.elem);
        end
        checks++;
        if (fail_data !== 8'(e.data)) begin
            errs++;
            $display("FAIL sa_data: got %h want %h", fail_data, e.data);
        end
        fault = 0;
    endtask

    task automatic test_coupling();
        int c;
        exp_t e;
        fault = 2;
        sb.push_back('{164, 1'b0, 1, 5, 2, 0});
        do_run(-10, -1, 1'b0, c);
        e = sb.pop_front();
        checks++;
        if (c != e.cyc || pass !== e.pass) begin
            errs++;
            $display("FAIL cf_done: got cyc=%0d pass=%b want %0d %b",
                     c, pass, e.cyc, e.pass);
        end
        checks++;
        if (int'(fail_count) < e.cnt) begin
            errs++;
            $display("FAIL cf_count: got %0d want >=%0d",
                     fail_count, e.cnt);
        end
        checks++;
        if (fail_addr !== 4'(e.addr) || fail_elem !== 3'(e.elem)
            || fail_data !== 8'(e.data)) begin
            errs++;
            $display("FAIL cf_where: got a=%0d e=%0d d=%h want %0d %0d %h",
                     fail_addr, fail_elem, fail_data,
                     e.addr, e.elem, e.data);
        end
        fault = 0;
    endtask

    task automatic test_abort();
        int c;
        int dones;
        exp_t e;
        fault = 0;
        do_run(-10, 50, 1'b0, c);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 ||
            mif.mem_write_read !== 1'b0) begin
            errs++;
            $display("FAIL ab_reset: got busy=%b done=%b we=%b want 0",
                     busy, done, mif.mem_write_read);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errs++;
            $display("FAIL ab_no_done: got %0d want 0", dones);
        end
        sb.push_back('{164, 1'b1, 0, 0, 0, 0});
        do_run(-10, -1, 1'b0, c);
        e = sb.pop_front();
        checks++;
        if (c != e.cyc || pass !== e.pass || fail_count !== 8'(e.cnt))
        begin
            errs++;
            $display("FAIL ab_rerun: got cyc=%0d pass=%b n=%0d want %0d %b %0d",
                     c, pass, fail_count, e.cyc, e.pass, e.cnt);
        end
    endtask

    task automatic test_start_ignored();
        int c;
        exp_t e;
        fault = 0;
        sb.push_back('{164, 1'b1, 0, 0, 0, 0});
        do_run(20, -1, 1'b0, c);
        e = sb.pop_front();
        checks++;
        if (c != e.cyc || pass !== e.pass) begin
            errs++;
            $display("FAIL ign_done: got cyc=%0d pass=%b want %0d %b",
                     c, pass, e.cyc, e.pass);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        exp_t e;
        fault = 1;
        sb.push_back('{164, 1'b0, 3, 3, 1, 1});
        sb.push_back('{164, 1'b1, 0, 0, 0, 0});
        do_run(-10, -1, 1'b1, c);
        e = sb.pop_front();
        checks++;
        if (c != e.cyc || fail_count !== 8'(e.cnt) ||
            fail_addr !== 4'(e.addr)) begin
            errs++;
            $display("FAIL b2b_first: got cyc=%0d n=%0d a=%0d want %0d %0d %0d",
                     c, fail_count, fail_addr, e.cyc, e.cnt, e.addr);
        end
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL b2b_busy_low: got %b want 0", busy);
        end
        fault = 0;
        @(posedge clk);
        wr_cnt = 0;
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL b2b_busy_high: got %b want 1", busy);
        end
        checks++;
        if ({pass, fail_count, fail_addr, fail_elem, fail_data} !== '0)
        begin
            errs++;
            $display("FAIL b2b_cleared: got %h want 0",
                     {pass, fail_count, fail_addr, fail_elem, fail_data});
        end
        c = 0;
        wait_done(-10, -1, c);
        e = sb.pop_front();
        checks++;
        if (c != e.cyc || pass !== e.pass || fail_count !== 8'(e.cnt))
        begin
            errs++;
            $display("FAIL b2b_second: got cyc=%0d pass=%b n=%0d want %0d %b %0d",
                     c, pass, fail_count, e.cyc, e.pass, e.cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck();
        test_coupling();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
